// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding, default oversampling and
// the 2-of-3 majority vote used for bit decisions.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  localparam int unsigned DEF_OVERSAMPLE = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-cycle tick every DIV clocks, held in phase 0 while clr=1.
// Latency: first tick DIV clocks after clr drops. No backpressure.
module uart_baud_tick #(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned DIV = (CLK_FREQ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with majority-voted mid-bit sampling and a single-entry valid/ready output.
// Latency ~9.5 bit times + 2-3 clks; a byte finishing while valid&&!ready is dropped (overrun).
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 60000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] MID   = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SMP0  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP1  = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] LASTS = SW'(OVERSAMPLE - 1);

  logic [1:0]    sync_q;
  logic          rxs;
  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          tick, mid, bitval;

  assign rxs = sync_q[1];

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (state_q == ST_IDLE),
    .tick (tick)
  );

  assign mid    = tick && (s_q == MID);
  assign bitval = maj3(smp_q[0], smp_q[1], rxs);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    bit_d   = bit_q;
    smp_d   = smp_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && ready) valid_d = 1'b0;

    // The sample counter free-runs across bits so mid points stay exactly OVERSAMPLE ticks apart.
    if (tick) begin
      s_d = (s_q == LASTS) ? '0 : s_q + 1'b1;
      if (s_q == SMP0) smp_d[0] = rxs;
      if (s_q == SMP1) smp_d[1] = rxs;
    end

    unique case (state_q)
      ST_IDLE: begin
        s_d   = '0;
        bit_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: begin
        if (mid) begin
          if (bitval) state_d = ST_IDLE;
          else begin
            state_d = ST_DATA;
            bit_d   = '0;
          end
        end
      end
      ST_DATA: begin
        if (mid) begin
          sr_d[bit_q] = bitval;
          bit_d       = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (mid) begin
          if (bitval) begin
            state_d = ST_IDLE;
            if (!valid_q || ready) begin
              data_d  = sr_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      s_q     <= '0;
      bit_q   <= '0;
      smp_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx};
      state_q <= state_d;
      s_q     <= s_d;
      bit_q   <= bit_d;
      smp_q   <= smp_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clks/bit (DIV=1): frame table plus hand-written corner cases.
module tb_uart_rx;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx #(
    .CLK_FREQ  (1600000),
    .BAUD      (100000),
    .OVERSAMPLE(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int n_vld_cyc = 0;
  int n_ferr    = 0;
  int n_ovr     = 0;
  int n_both    = 0;
  logic [7:0] acc[$];

  always @(negedge clk) begin
    if (reset) begin
      if (valid) n_vld_cyc++;
      if (valid && ready) acc.push_back(data);
      if (frame_err) n_ferr++;
      if (overrun) n_ovr++;
      if (frame_err && overrun) n_both++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    n_vld_cyc = 0;
    n_ferr    = 0;
    n_ovr     = 0;
    acc.delete();
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start bit, 8 data bits LSB first, then stop bit of the given value, 16 clks each.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clk); #1 rx = 1'b0;
    clocks(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      clocks(16);
    end
    rx = stop;
    clocks(16);
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop;
    logic [7:0] exp_data;
    int         exp_vld;
    int         exp_ferr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{8'h61, 1'b1, 8'h61, 1, 0};
    tbl[1] = '{8'h00, 1'b1, 8'h00, 1, 0};
    tbl[2] = '{8'hFF, 1'b1, 8'hFF, 1, 0};
    tbl[3] = '{8'h80, 1'b1, 8'h80, 1, 0};
    tbl[4] = '{8'hA5, 1'b1, 8'hA5, 1, 0};
    tbl[5] = '{8'h55, 1'b0, 8'h00, 0, 1};

    reset = 1'b0;
    rx    = 1'b1;
    ready = 1'b1;
    clocks(3);
    chk("rst_data",  {24'd0, data}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_flags", {30'd0, frame_err, overrun}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    reset = 1'b1;
    clocks(4);

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      send_frame(tbl[i].b, tbl[i].stop);
      if (!tbl[i].stop) begin
        clocks(40);
        chk("brk_busy_held", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        wait_idle("brk_release", 8);
        clocks(5);
        chk("brk_no_restart", {31'd0, busy}, 32'd0);
      end else begin
        clocks(4);
      end
      chk("tbl_vld_cycles", n_vld_cyc, tbl[i].exp_vld);
      chk("tbl_ferr", n_ferr, tbl[i].exp_ferr);
      chk("tbl_ovr", n_ovr, 32'd0);
      if (tbl[i].exp_vld != 0)
        chk("tbl_data", {24'd0, acc[acc.size() - 1]}, {24'd0, tbl[i].exp_data});
    end

    // back-to-back "abc"
    clear_mon();
    send_frame(8'h61, 1'b1);
    send_frame(8'h62, 1'b1);
    send_frame(8'h63, 1'b1);
    clocks(4);
    chk("abc_count", acc.size(), 32'd3);
    if (acc.size() == 3) begin
      chk("abc_0", {24'd0, acc[0]}, 32'h61);
      chk("abc_1", {24'd0, acc[1]}, 32'h62);
      chk("abc_2", {24'd0, acc[2]}, 32'h63);
    end
    chk("abc_flags", n_ferr + n_ovr, 32'd0);

    // short glitch on the start bit
    clear_mon();
    @(posedge clk); #1 rx = 1'b0;
    clocks(4);
    rx = 1'b1;
    wait_idle("glitch_idle", 12);
    clocks(4);
    chk("glitch_vld", n_vld_cyc, 32'd0);
    chk("glitch_flags", n_ferr + n_ovr, 32'd0);

    // overrun: old byte wins
    clear_mon();
    ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    clocks(4);
    chk("ovr_valid", {31'd0, valid}, 32'd1);
    chk("ovr_data",  {24'd0, data}, 32'h11);
    chk("ovr_pulses", n_ovr, 32'd1);
    ready = 1'b1;
    clocks(1);
    ready = 1'b0;
    @(negedge clk);
    chk("ovr_drain", {31'd0, valid}, 32'd0);

    // reset in the middle of a frame while a byte is pending
    send_frame(8'h77, 1'b1);
    clocks(2);
    chk("pre_rst_valid", {31'd0, valid}, 32'd1);
    @(posedge clk); #1 rx = 1'b0;
    clocks(16);
    for (int i = 0; i < 3; i++) begin
      rx = (8'hA5 >> i) & 8'h01;
      clocks(16);
    end
    chk("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, valid}, 32'd0);
    chk("mid_rst_data",  {24'd0, data}, 32'd0);
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    rx = 1'b1;
    ready = 1'b1;
    clocks(3);
    reset = 1'b1;
    clocks(3);
    clear_mon();
    send_frame(8'h3C, 1'b1);
    clocks(4);
    chk("post_rst_count", acc.size(), 32'd1);
    if (acc.size() == 1) chk("post_rst_data", {24'd0, acc[0]}, 32'h3C);

    // ready high exactly on the delivery edge: next byte loads, no overrun
    ready = 1'b0;
    send_frame(8'h44, 1'b1);
    clocks(2);
    chk("pend_data", {24'd0, data}, 32'h44);
    clear_mon();
    fork
      send_frame(8'h99, 1'b1);
      begin
        repeat (157) @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
      end
    join
    clocks(2);
    chk("coin_valid", {31'd0, valid}, 32'd1);
    chk("coin_data",  {24'd0, data}, 32'h99);
    chk("coin_ovr",   n_ovr, 32'd0);
    ready = 1'b1;
    clocks(2);

    chk("never_both", n_both, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
